// File: rtl/gelu_du_arb_pkg.sv
// Shared types and defaults for the GELU DU arbiter.
// State encoding, DU latency and default geometry.
package gelu_du_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int DU_LATENCY       = 4;
  localparam int DEF_N            = 4;
  localparam int DEF_W            = 32;
  localparam int DEF_MAX_INFLIGHT = 8;

endpackage

// File: rtl/gelu_du_arbiter_du_tag_fifo.sv
// In-order tag FIFO for the GELU DU arbiter.
// Holds the lane index of every request in flight.
module du_tag_fifo #(
  parameter int TW    = 2,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [TW-1:0]                tag_i,
  input  logic                         pop_i,
  output logic [TW-1:0]                tag_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign tag_o   = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Tag storage; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= tag_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/gelu_du_arbiter.sv
// Round-robin arbiter sharing one GELU DU between N lanes.
// Tags route in-order DU results back to the issuing lane.
module gelu_du_arbiter
  import gelu_du_arb_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int W            = DEF_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [N-1:0]                        req_valid,
  output logic [N-1:0]                        req_ready,
  input  logic [N*W-1:0]                      req_F,
  input  logic [N*W-1:0]                      req_s_xi,
  output logic                                du_valid_in,
  output logic [W-1:0]                        du_F,
  output logic [W-1:0]                        du_s_xi,
  input  logic                                du_valid_out,
  input  logic [W-1:0]                        du_exponent,
  input  logic                                du_div_by_zero,
  input  logic                                du_result_sign,
  output logic [N-1:0]                        resp_valid,
  output logic [W-1:0]                        resp_exponent,
  output logic                                resp_div_by_zero,
  output logic                                resp_result_sign,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic                                idle,
  output logic                                flush_done,
  output logic                                err_underflow
);

  localparam int TW = (N > 1) ? $clog2(N) : 1;

  if (MAX_INFLIGHT <= DU_LATENCY) begin : g_depth_chk
    $error("MAX_INFLIGHT must exceed DU latency");
  end

  arb_state_t    state_q;
  logic          flush_q;
  logic [TW-1:0] last_q;
  logic          dvi_q;
  logic [W-1:0]  f_q;
  logic [W-1:0]  s_q;
  logic [N-1:0]  rv_q;
  logic [W-1:0]  rexp_q;
  logic          rdbz_q;
  logic          rsgn_q;
  logic          err_q;

  logic [TW-1:0] sel;
  logic          hit;
  logic          grant_ok;
  logic          accept;
  logic          pop;
  logic [TW-1:0] head;
  logic          empty;
  logic          full;

  du_tag_fifo #(
    .TW    (TW),
    .DEPTH (MAX_INFLIGHT)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .tag_i   (sel),
    .pop_i   (pop),
    .tag_o   (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (inflight)
  );

  assign grant_ok = (state_q == RUN) & ~full;
  assign accept   = |req_ready;
  assign pop      = du_valid_out & ~empty;

  // Round-robin pick: first valid lane after the last grant.
  always_comb begin
    req_ready = '0;
    sel       = '0;
    hit       = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!hit && req_valid[(int'(last_q) + k) % N]) begin
        hit = 1'b1;
        sel = TW'((int'(last_q) + k) % N);
      end
    end
    if (grant_ok && hit) req_ready[sel] = 1'b1;
  end

  // Enable/drain state machine with the flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        IDLE:    if (enable) state_q <= RUN;
        RUN:     if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (inflight == '0 && !dvi_q) begin
            state_q <= IDLE;
            flush_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Issue registers toward the DU.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvi_q  <= 1'b0;
      f_q    <= '0;
      s_q    <= '0;
      last_q <= TW'(N - 1);
    end else begin
      dvi_q <= accept;
      if (accept) begin
        f_q    <= req_F[int'(sel)*W +: W];
        s_q    <= req_s_xi[int'(sel)*W +: W];
        last_q <= sel;
      end
    end
  end

  // Response registers and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q   <= '0;
      rexp_q <= '0;
      rdbz_q <= 1'b0;
      rsgn_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rv_q <= pop ? (N'(1) << head) : '0;
      if (pop) begin
        rexp_q <= du_exponent;
        rdbz_q <= du_div_by_zero;
        rsgn_q <= du_result_sign;
      end
      if (du_valid_out && empty) err_q <= 1'b1;
    end
  end

  assign du_valid_in      = dvi_q;
  assign du_F             = f_q;
  assign du_s_xi          = s_q;
  assign resp_valid       = rv_q;
  assign resp_exponent    = rexp_q;
  assign resp_div_by_zero = rdbz_q;
  assign resp_result_sign = rsgn_q;
  assign idle             = (state_q == IDLE);
  assign flush_done       = flush_q;
  assign err_underflow    = err_q;

endmodule

// File: tb/tb_gelu_du_arbiter.sv
// Testbench for gelu_du_arbiter.
// DU stub plus queue-based reference of grants and responses.
module tb_gelu_du_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MI = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_F;
  logic [N*W-1:0] req_s_xi;
  logic           du_valid_in;
  logic [W-1:0]   du_F;
  logic [W-1:0]   du_s_xi;
  logic           du_valid_out;
  logic [W-1:0]   du_exponent;
  logic           du_div_by_zero;
  logic           du_result_sign;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_exponent;
  logic           resp_div_by_zero;
  logic           resp_result_sign;
  logic [3:0]     inflight;
  logic           idle;
  logic           flush_done;
  logic           err_underflow;

  typedef struct packed {
    logic [31:0] e;
    logic        z;
    logic        s;
  } res_t;

  typedef struct {
    logic [N-1:0] vec;
    res_t         r;
    int           cyc;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic du_block;
  logic du_stray;
  res_t stray_r;
  logic [3:0] pv;
  res_t pr [4];

  gelu_du_arbiter #(.N(N), .W(W), .MAX_INFLIGHT(MI)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_F            (req_F),
    .req_s_xi         (req_s_xi),
    .du_valid_in      (du_valid_in),
    .du_F             (du_F),
    .du_s_xi          (du_s_xi),
    .du_valid_out     (du_valid_out),
    .du_exponent      (du_exponent),
    .du_div_by_zero   (du_div_by_zero),
    .du_result_sign   (du_result_sign),
    .resp_valid       (resp_valid),
    .resp_exponent    (resp_exponent),
    .resp_div_by_zero (resp_div_by_zero),
    .resp_result_sign (resp_result_sign),
    .inflight         (inflight),
    .idle             (idle),
    .flush_done       (flush_done),
    .err_underflow    (err_underflow)
  );

  always #5 clk = ~clk;

  // Stand-in DU: log2 of the quotient magnitude in Q5.26.
  function automatic res_t du_model(logic [31:0] f, logic [31:0] s);
    res_t r;
    logic [31:0] af;
    logic [31:0] as_;
    int mf;
    int ms;
    r.s = f[31] ^ s[31];
    r.z = (s == 0);
    r.e = '0;
    if (s != 0) begin
      af = f[31] ? -f : f;
      as_ = s[31] ? -s : s;
      mf = 0;
      ms = 0;
      for (int b = 0; b < 32; b++) begin
        if (af[b]) mf = b;
        if (as_[b]) ms = b;
      end
      r.e = 32'(mf - ms) << 26;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) pv <= '0;
    else pv <= {pv[2:0], du_valid_in};
    pr[0] <= du_model(du_F, du_s_xi);
    for (int k = 1; k < 4; k++) pr[k] <= pr[k-1];
  end

  assign du_valid_out = (pv[3] & ~du_block) | du_stray;
  assign {du_exponent, du_div_by_zero, du_result_sign} =
    du_stray ? stray_r : pr[3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (resp_valid != 0)
      obs_q.push_back('{vec: resp_valid,
        r: {resp_exponent, resp_div_by_zero, resp_result_sign},
        cyc: cyc});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    req_valid = '0;
    du_block = 1'b0;
    du_stray = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_ops();
    for (int l = 0; l < N; l++) begin
      req_F[l*W +: W] = $urandom;
      req_s_xi[l*W +: W] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    req_valid = '1;
    du_block = 1'b0;
    du_stray = 1'b0;
    stray_r = '0;
    rand_ops();
    tick();
    #1;
    checks++;
    if ({req_ready, du_valid_in, resp_valid, flush_done, err_underflow,
         resp_div_by_zero, resp_result_sign, idle} !== 15'b000000000000001) begin
      errors++;
      $display("FAIL reset_ctl: got rdy=%b dvi=%b rv=%b fd=%b err=%b idle=%b want 0,0,0,0,0,1",
        req_ready, du_valid_in, resp_valid, flush_done, err_underflow, idle);
    end
    checks++;
    if (du_F !== 0 || du_s_xi !== 0 || resp_exponent !== 0) begin
      errors++;
      $display("FAIL reset_data: got F=%h s=%h e=%h want 0",
        du_F, du_s_xi, resp_exponent);
    end
    checks++;
    if (inflight !== 0) begin
      errors++;
      $display("FAIL reset_inflight: got %0d want 0", inflight);
    end
  endtask

  task automatic test_single();
    int acc;
    do_reset();
    enable = 1'b1;
    tick();
    req_valid = 4'b0100;
    req_F[2*W +: W] = 32'h0400_0000;
    req_s_xi[2*W +: W] = 32'h0800_0000;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    acc = cyc;
    tick();
    req_valid = '0;
    checks++;
    if (du_valid_in !== 1'b1 || du_F !== 32'h0400_0000 || du_s_xi !== 32'h0800_0000) begin
      errors++;
      $display("FAIL single_issue: got v=%b F=%h s=%h want 1 04000000 08000000",
        du_valid_in, du_F, du_s_xi);
    end
    tick();
    checks++;
    if (du_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL single_dvi_len: got %b want 0", du_valid_in);
    end
    repeat (8) tick();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].vec !== 4'b0100 || obs_q[0].r.e !== 32'hFC00_0000 ||
          obs_q[0].r.s !== 1'b0) begin
        errors++;
        $display("FAIL single_resp: got rv=%b e=%h sg=%b want 0100 fc000000 0",
          obs_q[0].vec, obs_q[0].r.e, obs_q[0].r.s);
      end
      checks++;
      if (obs_q[0].cyc - acc != 6) begin
        errors++;
        $display("FAIL single_latency: got %0d want 6", obs_q[0].cyc - acc);
      end
    end
  endtask

  task automatic test_contention();
    int lane;
    do_reset();
    enable = 1'b1;
    tick();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1;
      lane = i % N;
      checks++;
      if (req_ready !== 4'(1 << lane)) begin
        errors++;
        $display("FAIL cont_grant[%0d]: got %b want %b", i, req_ready, 4'(1 << lane));
      end
      exp_q.push_back('{vec: 4'(1 << lane),
        r: du_model(req_F[lane*W +: W], req_s_xi[lane*W +: W]),
        cyc: cyc + 6});
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL cont_count: got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].vec !== exp_q[i].vec || obs_q[i].r !== exp_q[i].r ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL cont_resp[%0d]: got rv=%b r=%h c=%0d want rv=%b r=%h c=%0d",
          i, obs_q[i].vec, obs_q[i].r, obs_q[i].cyc,
          exp_q[i].vec, exp_q[i].r, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_div_by_zero();
    do_reset();
    enable = 1'b1;
    tick();
    req_valid = 4'b0010;
    req_F[1*W +: W] = $urandom | 32'h1;
    req_s_xi[1*W +: W] = '0;
    tick();
    req_valid = '0;
    repeat (8) tick();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL dbz_count: got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].vec !== 4'b0010 || obs_q[0].r.z !== 1'b1 || obs_q[0].r.e !== 0) begin
        errors++;
        $display("FAIL dbz_resp: got rv=%b z=%b e=%h want 0010 1 0",
          obs_q[0].vec, obs_q[0].r.z, obs_q[0].r.e);
      end
    end
  endtask

  task automatic test_random();
    int last;
    int found;
    int l;
    logic [N-1:0] want;
    do_reset();
    enable = 1'b1;
    tick();
    last = N - 1;
    for (int i = 0; i < 60; i++) begin
      req_valid = N'($urandom);
      rand_ops();
      #1;
      found = -1;
      for (int k = 1; k <= N; k++) begin
        l = (last + k) % N;
        if (found < 0 && req_valid[l]) found = l;
      end
      want = (found < 0) ? '0 : 4'(1 << found);
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got %b want %b (valid %b)",
          i, req_ready, want, req_valid);
      end
      if (found >= 0) begin
        last = found;
        exp_q.push_back('{vec: want,
          r: du_model(req_F[found*W +: W], req_s_xi[found*W +: W]),
          cyc: cyc + 6});
      end
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].vec !== exp_q[i].vec || obs_q[i].r !== exp_q[i].r ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL rand_resp[%0d]: got rv=%b r=%h c=%0d want rv=%b r=%h c=%0d",
          i, obs_q[i].vec, obs_q[i].r, obs_q[i].cyc,
          exp_q[i].vec, exp_q[i].r, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    enable = 1'b1;
    du_block = 1'b1;
    tick();
    req_valid = 4'b0001;
    rand_ops();
    for (int i = 0; i < MI; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL full_fill[%0d]: got %b want 0001", i, req_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (inflight !== 4'd8 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL full_stall: got inflight=%0d rdy=%b want 8 0000",
        inflight, req_ready);
    end
    tick();
    stray_r.e = $urandom;
    stray_r.z = 1'b0;
    stray_r.s = 1'b0;
    du_stray = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL full_no_bypass: got %b want 0000", req_ready);
    end
    tick();
    du_stray = 1'b0;
    #1;
    checks++;
    if (inflight !== 4'd7 || resp_valid !== 4'b0001 ||
        resp_exponent !== stray_r.e) begin
      errors++;
      $display("FAIL full_pop: got inflight=%0d rv=%b e=%h want 7 0001 %h",
        inflight, resp_valid, resp_exponent, stray_r.e);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL full_resume: got %b want 0001", req_ready);
    end
    tick();
    checks++;
    if (inflight !== 4'd8) begin
      errors++;
      $display("FAIL full_refill: got %0d want 8", inflight);
    end
  endtask

  task automatic test_drain();
    int last_acc;
    int flushes;
    int fcyc;
    int leak;
    do_reset();
    enable = 1'b1;
    tick();
    req_valid = 4'b0111;
    rand_ops();
    last_acc = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << i)) begin
        errors++;
        $display("FAIL drain_grant[%0d]: got %b want %b", i, req_ready, 4'(1 << i));
      end
      last_acc = cyc;
      tick();
    end
    enable = 1'b0;
    req_valid = '0;
    tick();
    req_valid = '1;
    flushes = 0;
    fcyc = -1;
    leak = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (req_ready != 0) leak++;
      if (flush_done) begin
        flushes++;
        fcyc = cyc;
      end
      tick();
    end
    checks++;
    if (leak != 0) begin
      errors++;
      $display("FAIL drain_no_grant: got %0d grant cycles want 0", leak);
    end
    checks++;
    if (flushes != 1) begin
      errors++;
      $display("FAIL drain_flush_count: got %0d want 1", flushes);
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL drain_resp_count: got %0d want 3", obs_q.size());
    end else begin
      checks++;
      if (fcyc <= obs_q[2].cyc || fcyc - last_acc < 6) begin
        errors++;
        $display("FAIL drain_flush_time: got %0d want > %0d and >= %0d",
          fcyc, obs_q[2].cyc, last_acc + 6);
      end
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_reset_underflow();
    do_reset();
    enable = 1'b1;
    tick();
    req_valid = '1;
    rand_ops();
    repeat (6) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({req_ready, du_valid_in, resp_valid, flush_done, err_underflow,
         resp_div_by_zero, resp_result_sign, idle} !== 15'b000000000000001) begin
      errors++;
      $display("FAIL midrst_ctl: got rdy=%b dvi=%b rv=%b fd=%b err=%b idle=%b want 0,0,0,0,0,1",
        req_ready, du_valid_in, resp_valid, flush_done, err_underflow, idle);
    end
    checks++;
    if (du_F !== 0 || du_s_xi !== 0 || resp_exponent !== 0 || inflight !== 0) begin
      errors++;
      $display("FAIL midrst_data: got F=%h s=%h e=%h n=%0d want 0",
        du_F, du_s_xi, resp_exponent, inflight);
    end
    rst = 1'b0;
    enable = 1'b0;
    req_valid = '0;
    obs_q.delete();
    repeat (8) tick();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_stale: got %0d responses want 0", obs_q.size());
    end
    stray_r = '0;
    du_stray = 1'b1;
    tick();
    du_stray = 1'b0;
    checks++;
    if (err_underflow !== 1'b1 || resp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL underflow_set: got err=%b rv=%b want 1 0000",
        err_underflow, resp_valid);
    end
    repeat (3) tick();
    checks++;
    if (err_underflow !== 1'b1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL underflow_sticky: got err=%b resp=%0d want 1 0",
        err_underflow, obs_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_F = '0;
    req_s_xi = '0;
    test_reset();
    test_single();
    test_contention();
    test_div_by_zero();
    test_random();
    test_full();
    test_drain();
    test_reset_underflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
